// File: rtl/mdu_pkg.sv
// Shared MDU definitions: request kinds, MDU op codes and controller state encoding.
// Also used by the MDU itself.
package mdu_pkg;

   typedef enum logic [3:0] {
      KindMult  = 4'd0,
      KindMultu = 4'd1,
      KindDiv   = 4'd2,
      KindDivu  = 4'd3,
      KindMtlo  = 4'd4,
      KindMthi  = 4'd5,
      KindMflo  = 4'd6,
      KindMfhi  = 4'd7
   } mdu_kind_e;

   typedef enum logic [2:0] {
      OpNone  = 3'd0,
      OpMult  = 3'd1,
      OpMultu = 3'd2,
      OpDiv   = 3'd3,
      OpDivu  = 3'd4,
      OpMtlo  = 3'd5,
      OpMthi  = 3'd6
   } mdu_op_e;

   typedef enum logic [1:0] {
      StIdle   = 2'd0,
      StLaunch = 2'd1,
      StResp   = 2'd2
   } mdu_state_e;

   // Op codes are the request kind shifted up by one so that zero means "no op".
   function automatic mdu_op_e kind_to_op(input logic [3:0] kind);
      return mdu_op_e'(kind[2:0] + 3'd1);
   endfunction

   function automatic logic is_mf(input logic [3:0] kind);
      return (kind == KindMflo) || (kind == KindMfhi);
   endfunction

   function automatic logic is_mult_div(input logic [3:0] kind);
      return kind <= KindDivu;
   endfunction

endpackage

// File: rtl/mdu_ctrl_sat_counter.sv
// Saturating up-counter: holds at all-ones instead of wrapping.
module mdu_ctrl_sat_counter #(
   parameter int unsigned Width = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             inc_i,
   output logic [Width-1:0] count_o
);

   logic [Width-1:0] count_q, count_d;

   always_comb begin
      count_d = count_q;
      if (inc_i && (count_q != '1)) begin
         count_d = count_q + Width'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count_o = count_q;

endmodule

// File: rtl/mdu_ctrl.sv
// Pipeline-side controller for the multiply/divide unit: accepts MDU instructions,
// issues one-cycle MDU commands and returns HI/LO reads through a valid/ready response.
module mdu_ctrl
   import mdu_pkg::*;
#(
   parameter int unsigned OP_W = 3
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            req_valid_i,
   input  logic [3:0]      req_kind_i,
   input  logic [31:0]     req_a_i,
   input  logic [31:0]     req_b_i,
   output logic            req_ready_o,
   output logic            resp_valid_o,
   output logic [31:0]     resp_data_o,
   input  logic            resp_ready_i,
   output logic            stall_o,
   output logic [31:0]     stall_cnt_o,
   output logic            mdu_start_o,
   output logic [OP_W-1:0] mdu_op_o,
   output logic [31:0]     mdu_a_o,
   output logic [31:0]     mdu_b_o,
   output logic            mdu_rdsel_o,
   input  logic [31:0]     mdu_out_i,
   input  logic            mdu_busy_i
);

   mdu_state_e      state_q;
   logic [3:0]      kind_q;
   logic [31:0]     a_q, b_q;
   logic [OP_W-1:0] op_q;
   logic            start_q;
   logic            resp_valid_q;
   logic            accept;

   // Reserved kinds (bit 3 set) are never accepted, so they stall indefinitely.
   assign req_ready_o = (state_q == StIdle) && !mdu_busy_i && !req_kind_i[3];
   assign accept      = req_valid_i && req_ready_o;
   assign stall_o     = req_valid_i && !req_ready_o;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= StIdle;
         kind_q       <= '0;
         a_q          <= '0;
         b_q          <= '0;
         op_q         <= '0;
         start_q      <= 1'b0;
         resp_valid_q <= 1'b0;
      end else begin
         case (state_q)
            StIdle: begin
               if (accept) begin
                  kind_q <= req_kind_i;
                  a_q    <= req_a_i;
                  b_q    <= req_b_i;
                  if (is_mf(req_kind_i)) begin
                     resp_valid_q <= 1'b1;
                     state_q      <= StResp;
                  end else begin
                     op_q    <= OP_W'(kind_to_op(req_kind_i));
                     start_q <= is_mult_div(req_kind_i);
                     state_q <= StLaunch;
                  end
               end
            end
            StLaunch: begin
               // The MDU acts on any nonzero op every cycle, so the command lasts one cycle.
               op_q    <= '0;
               start_q <= 1'b0;
               state_q <= StIdle;
            end
            StResp: begin
               if (resp_ready_i) begin
                  resp_valid_q <= 1'b0;
                  state_q      <= StIdle;
               end
            end
            default: begin
               op_q         <= '0;
               start_q      <= 1'b0;
               resp_valid_q <= 1'b0;
               state_q      <= StIdle;
            end
         endcase
      end
   end

   // Masked during reset so an aborted launch never reaches the MDU.
   assign mdu_op_o    = reset ? '0 : op_q;
   assign mdu_start_o = start_q && !reset;
   assign mdu_a_o     = a_q;
   assign mdu_b_o     = b_q;

   assign resp_valid_o = resp_valid_q;
   assign mdu_rdsel_o  = resp_valid_q && (kind_q == KindMfhi);
   assign resp_data_o  = resp_valid_q ? mdu_out_i : '0;

   mdu_ctrl_sat_counter #(
      .Width(32)
   ) u_stall_cnt (
      .clk    (clk),
      .reset  (reset),
      .inc_i  (stall_o),
      .count_o(stall_cnt_o)
   );

endmodule

// File: tb/tb_mdu_ctrl.sv
// Bench for mdu_ctrl: behavioural MDU harness, architectural HI/LO reference,
// directed vector table, reset corner sequences and a randomized instruction stream.
module tb_mdu_ctrl;

   localparam int MulLat = 3;
   localparam int DivLat = 8;

   logic        clk = 1'b0;
   logic        reset;
   logic        req_valid;
   logic [3:0]  req_kind;
   logic [31:0] req_a, req_b;
   logic        req_ready;
   logic        resp_valid;
   logic [31:0] resp_data;
   logic        resp_ready;
   logic        stall;
   logic [31:0] stall_cnt;
   logic        mdu_start;
   logic [2:0]  mdu_op;
   logic [31:0] mdu_a, mdu_b;
   logic        mdu_rdsel;
   logic [31:0] mdu_out;
   logic        mdu_busy;

   always #5 clk = ~clk;

   mdu_ctrl #(.OP_W(3)) dut (
      .clk         (clk),
      .reset       (reset),
      .req_valid_i (req_valid),
      .req_kind_i  (req_kind),
      .req_a_i     (req_a),
      .req_b_i     (req_b),
      .req_ready_o (req_ready),
      .resp_valid_o(resp_valid),
      .resp_data_o (resp_data),
      .resp_ready_i(resp_ready),
      .stall_o     (stall),
      .stall_cnt_o (stall_cnt),
      .mdu_start_o (mdu_start),
      .mdu_op_o    (mdu_op),
      .mdu_a_o     (mdu_a),
      .mdu_b_o     (mdu_b),
      .mdu_rdsel_o (mdu_rdsel),
      .mdu_out_i   (mdu_out),
      .mdu_busy_i  (mdu_busy)
   );

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, got, exp, cyc);
      end
   endtask

   // Architectural effect of kinds 0-5 on {HI,LO}, in plain arithmetic.
   function automatic logic [63:0] ref_exec(input int kind, input logic [31:0] a,
                                            input logic [31:0] b, input logic [63:0] hl);
      longint      sa, sb;
      int          qa, qb;
      logic [63:0] r;
      r = hl;
      case (kind)
         0: begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            r  = 64'(sa * sb);
         end
         1: r = {32'd0, a} * {32'd0, b};
         2: begin
            qa = $signed(a);
            qb = $signed(b);
            if (qb != 0) r = {32'(qa % qb), 32'(qa / qb)};
         end
         3: if (b != 0) r = {a % b, a / b};
         4: r[31:0] = a;
         5: r[63:32] = a;
         default: ;
      endcase
      return r;
   endfunction

   // Cycle counter and MDU harness.
   int          cyc = 0;
   logic [31:0] h_hi, h_lo;
   int          busy_cnt;
   int          n_starts = 0;

   always @(posedge clk) cyc <= cyc + 1;

   always @(posedge clk) begin
      if (reset) begin
         h_hi     <= '0;
         h_lo     <= '0;
         busy_cnt <= 0;
      end else begin
         if (mdu_op != 3'd0) {h_hi, h_lo} <= ref_exec(int'(mdu_op) - 1, mdu_a, mdu_b, {h_hi, h_lo});
         if (mdu_start) begin
            busy_cnt <= (mdu_op >= 3'd3) ? DivLat : MulLat;
            n_starts <= n_starts + 1;
         end else if (busy_cnt > 0) begin
            busy_cnt <= busy_cnt - 1;
         end
      end
   end

   assign mdu_busy = (busy_cnt != 0);
   assign mdu_out  = mdu_rdsel ? h_hi : h_lo;

   // Reference state.
   logic [63:0] ref_hl     = '0;
   int          exp_stall  = 0;
   int          free_at    = 0;
   int          launch_cyc = -1;
   logic [2:0]  launch_op  = '0;
   logic        launch_st  = 1'b0;
   logic [31:0] launch_a   = '0;
   logic [31:0] launch_b   = '0;
   logic        exp_resp   = 1'b0;
   logic        mon_en     = 1'b0;

   always @(negedge clk) begin
      if (mon_en) begin
         logic in_launch;
         in_launch = (cyc == launch_cyc) && !reset;
         check("mdu_op", 64'(mdu_op), in_launch ? 64'(launch_op) : 64'd0);
         check("mdu_start", 64'(mdu_start), 64'(in_launch && launch_st));
         if (in_launch) begin
            check("mdu_a", 64'(mdu_a), 64'(launch_a));
            check("mdu_b", 64'(mdu_b), 64'(launch_b));
         end
         check("resp_valid", 64'(resp_valid), 64'(exp_resp));
         if (!exp_resp) begin
            check("resp_data_idle", 64'(resp_data), 64'd0);
            check("rdsel_idle", 64'(mdu_rdsel), 64'd0);
         end
         check("stall_cnt", 64'(stall_cnt), 64'(exp_stall));
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_idle();
      int n = 0;
      req_valid = 1'b0;
      while ((cyc < free_at || mdu_busy) && n < 100) begin
         tick();
         n++;
      end
      if (n >= 100) check("wait_idle_timeout", 64'd1, 64'd0);
   endtask

   task automatic issue(input logic [3:0] kind, input logic [31:0] a, input logic [31:0] b,
                        input int rr_wait, output logic [31:0] got);
      logic  acc = 1'b0;
      logic  er;
      int    n   = 0;
      logic [31:0] exp;
      got       = '0;
      req_valid = 1'b1;
      req_kind  = kind;
      req_a     = a;
      req_b     = b;
      while (!acc && n < 200) begin
         @(negedge clk);
         er = (cyc >= free_at) && !mdu_busy && (kind < 4'd8);
         check("req_ready", 64'(req_ready), 64'(er));
         check("stall", 64'(stall), 64'(!er));
         acc = req_ready;
         tick();
         if (!er) exp_stall++;
         n++;
      end
      req_valid = 1'b0;
      req_kind  = 4'($urandom);
      if (!acc) begin
         check("accept_timeout", 64'd1, 64'd0);
         return;
      end
      if (kind <= 4'd5) begin
         launch_cyc = cyc;
         launch_op  = 3'(kind) + 3'd1;
         launch_st  = (kind <= 4'd3);
         launch_a   = a;
         launch_b   = b;
         free_at    = cyc + 1;
         ref_hl     = ref_exec(int'(kind), a, b, ref_hl);
      end else begin
         exp      = (kind == 4'd7) ? ref_hl[63:32] : ref_hl[31:0];
         exp_resp = 1'b1;
         for (int w = 0; w <= rr_wait; w++) begin
            resp_ready = (w == rr_wait);
            @(negedge clk);
            check("resp_data", 64'(resp_data), 64'(exp));
            check("resp_rdsel", 64'(mdu_rdsel), 64'(kind == 4'd7));
            check("ready_in_resp", 64'(req_ready), 64'd0);
            got = resp_data;
            tick();
         end
         resp_ready = 1'b0;
         exp_resp   = 1'b0;
         free_at    = cyc;
      end
   endtask

   task automatic present_reserved(input logic [3:0] kind, input int ncyc);
      req_valid = 1'b1;
      req_kind  = kind;
      for (int i = 0; i < ncyc; i++) begin
         @(negedge clk);
         check("reserved_ready", 64'(req_ready), 64'd0);
         check("reserved_stall", 64'(stall), 64'd1);
         tick();
         exp_stall++;
      end
      req_valid = 1'b0;
   endtask

   typedef struct {
      logic [3:0]  kind;
      logic [31:0] a;
      logic [31:0] b;
      int          rr;
      logic [31:0] exp;
   } vec_t;

   vec_t tbl[17];

   initial begin
      logic [31:0] got;
      int          s0, st0;
      logic [3:0]  k;
      logic [31:0] a, b;

      tbl[0]  = '{4'd0, 32'd7, 32'hFFFF_FFFD, 0, 32'h0};
      tbl[1]  = '{4'd6, 32'h0, 32'h0, 3, 32'hFFFF_FFEB};
      tbl[2]  = '{4'd7, 32'h0, 32'h0, 0, 32'hFFFF_FFFF};
      tbl[3]  = '{4'd3, 32'd100, 32'd7, 0, 32'h0};
      tbl[4]  = '{4'd6, 32'h0, 32'h0, 0, 32'd14};
      tbl[5]  = '{4'd7, 32'h0, 32'h0, 0, 32'd2};
      tbl[6]  = '{4'd5, 32'h1234_5678, 32'h0, 0, 32'h0};
      tbl[7]  = '{4'd7, 32'h0, 32'h0, 1, 32'h1234_5678};
      tbl[8]  = '{4'd4, 32'hDEAD_BEEF, 32'h0, 0, 32'h0};
      tbl[9]  = '{4'd6, 32'h0, 32'h0, 2, 32'hDEAD_BEEF};
      tbl[10] = '{4'd1, 32'hFFFF_FFFF, 32'd2, 0, 32'h0};
      tbl[11] = '{4'd6, 32'h0, 32'h0, 0, 32'hFFFF_FFFE};
      tbl[12] = '{4'd7, 32'h0, 32'h0, 0, 32'h1};
      tbl[13] = '{4'd0, 32'd3, 32'd5, 0, 32'h0};
      tbl[14] = '{4'd2, 32'hFFFF_FFF9, 32'd2, 0, 32'h0};
      tbl[15] = '{4'd6, 32'h0, 32'h0, 0, 32'hFFFF_FFFD};
      tbl[16] = '{4'd7, 32'h0, 32'h0, 0, 32'hFFFF_FFFF};

      reset      = 1'b1;
      req_valid  = 1'b0;
      req_kind   = '0;
      req_a      = '0;
      req_b      = '0;
      resp_ready = 1'b0;
      repeat (3) tick();
      @(negedge clk);
      check("rst_resp_valid", 64'(resp_valid), 64'd0);
      check("rst_mdu_op", 64'(mdu_op), 64'd0);
      check("rst_stall_cnt", 64'(stall_cnt), 64'd0);
      tick();
      reset   = 1'b0;
      free_at = cyc;
      mon_en  = 1'b1;
      @(negedge clk);
      check("rst_req_ready", 64'(req_ready), 64'd1);
      check("rst_mdu_a", 64'(mdu_a), 64'd0);
      check("rst_mdu_b", 64'(mdu_b), 64'd0);
      check("rst_resp_data", 64'(resp_data), 64'd0);
      tick();

      // Directed vectors, issued back to back.
      s0 = n_starts;
      st0 = 0;
      for (int i = 0; i < 17; i++) begin
         if (i == 3) st0 = exp_stall;
         issue(tbl[i].kind, tbl[i].a, tbl[i].b, tbl[i].rr, got);
         if (tbl[i].kind >= 4'd6) check($sformatf("vec%0d", i), 64'(got), 64'(tbl[i].exp));
         if (i == 2) check("mult_one_start", 64'(n_starts - s0), 64'd1);
         if (i == 4) check("divu_stall_cycles", 64'(exp_stall - st0), 64'(DivLat + 1));
      end

      // Reserved kinds hold stall high and are never accepted.
      wait_idle();
      present_reserved(4'd9, 4);
      present_reserved(4'd15, 2);

      // Reset during the response cycle drops the response.
      wait_idle();
      req_valid = 1'b1;
      req_kind  = 4'd6;
      @(negedge clk);
      check("mf_accept", 64'(req_ready), 64'd1);
      tick();
      req_valid = 1'b0;
      exp_resp  = 1'b1;
      reset     = 1'b1;
      tick();
      reset     = 1'b0;
      exp_resp  = 1'b0;
      exp_stall = 0;
      ref_hl    = '0;
      free_at   = cyc;
      @(negedge clk);
      check("rst_resp_valid2", 64'(resp_valid), 64'd0);
      check("rst_stall_cnt2", 64'(stall_cnt), 64'd0);
      check("rst_mdu_op2", 64'(mdu_op), 64'd0);
      tick();

      // Reset during launch: no start reaches the MDU.
      issue(4'd4, 32'hCAFE_0001, 32'h0, 0, got);
      issue(4'd0, 32'd11, 32'd13, 0, got);
      s0 = n_starts;
      reset = 1'b1;
      tick();
      reset     = 1'b0;
      exp_stall = 0;
      ref_hl    = '0;
      free_at   = cyc;
      check("aborted_start", 64'(n_starts - s0), 64'd0);
      issue(4'd6, 32'h0, 32'h0, 0, got);
      check("lo_after_abort", 64'(got), 64'd0);
      issue(4'd7, 32'h0, 32'h0, 0, got);
      check("hi_after_abort", 64'(got), 64'd0);

      // Randomized instruction stream.
      for (int i = 0; i < 250; i++) begin
         if ($urandom_range(0, 19) == 0) begin
            wait_idle();
            present_reserved(4'($urandom_range(8, 15)), $urandom_range(1, 3));
         end
         k = 4'($urandom_range(0, 7));
         a = $urandom;
         b = $urandom;
         if ($urandom_range(0, 3) == 0) a = 32'($urandom_range(0, 20));
         if (k == 4'd2 || k == 4'd3) begin
            if ($urandom_range(0, 1) == 1) b = 32'($urandom_range(1, 50));
            if (b == 32'd0) b = 32'd1;
            if (k == 4'd2 && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) b = 32'd3;
         end
         issue(k, a, b, $urandom_range(0, 3), got);
         repeat ($urandom_range(0, 2)) tick();
      end

      wait_idle();
      repeat (3) tick();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "watchdog");
   end

endmodule
